mux_n_to_1_stream: RTL and testbench

MUX_N_TO_1_STREAM -- requirements
Module: mux_n_to_1_stream

---
 rtl/mux_n_to_1_stream.sv | 157 +++++++++++++++
 tb/tb_mux_n_to_1_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_stream.sv
// mux_n_to_1_stream
//
// An N-to-1 multiplexer for valid/ready streams that locks onto one channel
// for a whole packet. In IDLE the requested select is sampled. An in-range
// select locks that channel. An out-of-range select produces a one-cycle
// error pulse. While LOCKED, beats from the locked channel pass through a
// single output register. The FSM returns to IDLE on the edge that accepts
// the beat marked last.
//
// Optional feature macro: MUX_OUT_BAR_EN.
// When it is defined, an o_out_bar register holds the bitwise complement of
// o_out. When it is undefined, the port and its logic do not exist.

module mux_n_to_1_stream #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N*WIDTH-1:0] i_in_data,
  input  logic [N-1:0]       i_in_valid,
  input  logic [N-1:0]       i_in_last,
  output logic [N-1:0]       o_in_ready,
  input  logic [SEL_W-1:0]   i_sel,
  output logic [WIDTH-1:0]   o_out,
  output logic               o_out_valid,
  output logic               o_out_last,
  input  logic               i_out_ready,
`ifdef MUX_OUT_BAR_EN
  output logic [WIDTH-1:0]   o_out_bar,
`endif
  output logic               o_busy,
  output logic               o_sel_err
);

  // The channel count, widened by one bit so it can be compared against
  // any select value, including all-ones.
  localparam logic [SEL_W:0] NUM_CH = (SEL_W+1)'(N);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_cur;
  logic [WIDTH-1:0]   r_out;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_sel_err;
`ifdef MUX_OUT_BAR_EN
  logic [WIDTH-1:0]   r_out_bar;
`endif

  logic [WIDTH-1:0]   w_cur_data;
  logic               w_cur_valid;
  logic               w_cur_last;
  logic               w_locked;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_sel_ok;

  assign w_locked    = (r_state == ST_LOCKED);
  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_accept    = w_locked && w_cur_valid && w_slot_free;
  assign w_sel_ok    = ({1'b0, i_sel} < NUM_CH);

  // Pick the locked channel's data, valid and last. The other channels
  // never reach any output.
  always_comb begin
    w_cur_data  = '0;
    w_cur_valid = 1'b0;
    w_cur_last  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (r_cur == SEL_W'(k)) begin
        w_cur_data  = i_in_data[k*WIDTH +: WIDTH];
        w_cur_valid = i_in_valid[k];
        w_cur_last  = i_in_last[k];
      end
    end
  end

  // Drive ready to the locked channel only. Ready is asserted when the
  // output register is empty or is being drained this cycle.
  always_comb begin
    o_in_ready = '0;
    for (int k = 0; k < N; k++) begin
      o_in_ready[k] = w_locked && (r_cur == SEL_W'(k)) && w_slot_free;
    end
  end

  // Lock control: sample the select in IDLE, and release the lock on the
  // accepted last beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_ok) begin
            r_cur   <= i_sel;
            r_state <= ST_LOCKED;
          end else begin
            r_sel_err <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_cur_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on accept, drop valid once downstream takes the
  // beat, and otherwise hold everything steady.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out       <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_cur_data;
      r_out_last  <= w_cur_last;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUX_OUT_BAR_EN
  // The complement register loads together with r_out, so it always
  // mirrors ~r_out. This includes the all-ones value after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_bar <= '1;
    end else if (w_accept) begin
      r_out_bar <= ~w_cur_data;
    end
  end

  assign o_out_bar = r_out_bar;
`endif

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = w_locked;
  assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Directed testbench for mux_n_to_1_stream.
// dut is the default configuration (N=4, WIDTH=8). dut3 has N=3 and is
// used for the out-of-range select case. The complement checks are
// compiled in only when MUX_OUT_BAR_EN is defined.

module tb_mux_n_to_1_stream;

  logic        clock;
  logic        reset;
  logic [31:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  inLast;
  logic [3:0]  inReady;
  logic [1:0]  sel;
  logic [7:0]  outData;
  logic        outValid;
  logic        outLast;
  logic        outReady;
  logic        busy;
  logic        selErr;
`ifdef MUX_OUT_BAR_EN
  logic [7:0]  outBar;
`endif

  logic [23:0] inData3;
  logic [2:0]  inValid3;
  logic [2:0]  inLast3;
  logic [2:0]  inReady3;
  logic [1:0]  sel3;
  logic [7:0]  outData3;
  logic        outValid3;
  logic        outLast3;
  logic        busy3;
  logic        selErr3;
`ifdef MUX_OUT_BAR_EN
  logic [7:0]  outBar3;
`endif

  int total;
  int bad;

  mux_n_to_1_stream #(.N(4), .WIDTH(8), .SEL_W(2)) dut (
    .i_clk(clock), .i_rst(reset),
    .i_in_data(inData), .i_in_valid(inValid), .i_in_last(inLast),
    .o_in_ready(inReady), .i_sel(sel),
    .o_out(outData), .o_out_valid(outValid), .o_out_last(outLast),
    .i_out_ready(outReady),
`ifdef MUX_OUT_BAR_EN
    .o_out_bar(outBar),
`endif
    .o_busy(busy), .o_sel_err(selErr)
  );

  mux_n_to_1_stream #(.N(3), .WIDTH(8), .SEL_W(2)) dut3 (
    .i_clk(clock), .i_rst(reset),
    .i_in_data(inData3), .i_in_valid(inValid3), .i_in_last(inLast3),
    .o_in_ready(inReady3), .i_sel(sel3),
    .o_out(outData3), .o_out_valid(outValid3), .o_out_last(outLast3),
    .i_out_ready(1'b1),
`ifdef MUX_OUT_BAR_EN
    .o_out_bar(outBar3),
`endif
    .o_busy(busy3), .o_sel_err(selErr3)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one beat onto one channel of the main DUT.
  task automatic applyStimulus(input int ch, input logic [7:0] d,
                               input logic v, input logic l);
    inData[ch*8 +: 8] = d;
    inValid[ch]       = v;
    inLast[ch]        = l;
  endtask

  // Advance past the next rising edge so that registered outputs have settled.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Apply one reset edge with all channels quiet, then release reset.
  task automatic doReset();
    reset    = 1'b1;
    inValid  = '0;
    inLast   = '0;
    inValid3 = '0;
    inLast3  = '0;
    sel      = '0;
    sel3     = '0;
    outReady = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    inData   = '0;
    inValid  = '0;
    inLast   = '0;
    sel      = '0;
    outReady = 1'b1;
    inData3  = '0;
    inValid3 = '0;
    inLast3  = '0;
    sel3     = '0;

    // Reset state of both instances.
    reset = 1'b1;
    step();
    checkOutput("rst_out", 32'(outData), 32'h00);
    checkOutput("rst_valid", 32'(outValid), 32'h0);
    checkOutput("rst_last", 32'(outLast), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ready", 32'(inReady), 32'h0);
    checkOutput("rst_selerr", 32'(selErr), 32'h0);
    checkOutput("rst3_busy", 32'(busy3), 32'h0);
`ifdef MUX_OUT_BAR_EN
    checkOutput("rst_bar", 32'(outBar), 32'hFF);
`endif

    // Two-beat packet on channel 2 while the other channels carry noise.
    doReset();
    sel = 2'd2;
    applyStimulus(2, 8'hA5, 1'b1, 1'b0);
    applyStimulus(0, 8'h11, 1'b1, 1'b1);
    applyStimulus(1, 8'h22, 1'b1, 1'b1);
    applyStimulus(3, 8'h33, 1'b1, 1'b1);
    step();
    checkOutput("t1_busy_lock", 32'(busy), 32'h1);
    checkOutput("t1_valid_lock", 32'(outValid), 32'h0);
    #1;
    checkOutput("t1_ready_lock", 32'(inReady), 32'h4);
    step();
    checkOutput("t1_out0", 32'(outData), 32'hA5);
    checkOutput("t1_valid0", 32'(outValid), 32'h1);
    checkOutput("t1_last0", 32'(outLast), 32'h0);
`ifdef MUX_OUT_BAR_EN
    checkOutput("t1_bar0", 32'(outBar), 32'h5A);
`endif
    applyStimulus(2, 8'h3C, 1'b1, 1'b1);
    step();
    checkOutput("t1_out1", 32'(outData), 32'h3C);
    checkOutput("t1_last1", 32'(outLast), 32'h1);
    checkOutput("t1_busy_end", 32'(busy), 32'h0);
`ifdef MUX_OUT_BAR_EN
    checkOutput("t1_bar1", 32'(outBar), 32'hC3);
`endif
    #1;
    checkOutput("t1_ready_idle", 32'(inReady), 32'h0);

    // Lock channel 1, then move the select to 3 in the middle of the packet.
    doReset();
    sel = 2'd1;
    applyStimulus(1, 8'h10, 1'b1, 1'b0);
    applyStimulus(3, 8'hEE, 1'b1, 1'b0);
    step();
    sel = 2'd3;
    #1;
    checkOutput("t2_ready_a", 32'(inReady), 32'h2);
    step();
    checkOutput("t2_out0", 32'(outData), 32'h10);
    applyStimulus(1, 8'h11, 1'b1, 1'b0);
    #1;
    checkOutput("t2_ready_b", 32'(inReady), 32'h2);
    step();
    checkOutput("t2_out1", 32'(outData), 32'h11);
    applyStimulus(1, 8'h12, 1'b1, 1'b1);
    #1;
    checkOutput("t2_ready_c", 32'(inReady), 32'h2);
    step();
    checkOutput("t2_out2", 32'(outData), 32'h12);
    checkOutput("t2_last2", 32'(outLast), 32'h1);

    // Backpressure: the output stalls for three cycles with a beat pending.
    doReset();
    sel      = 2'd0;
    outReady = 1'b0;
    applyStimulus(0, 8'h21, 1'b1, 1'b0);
    step();
    #1;
    checkOutput("t3_ready_empty", 32'(inReady), 32'h1);
    step();
    applyStimulus(0, 8'h22, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      #1;
      checkOutput("t3_hold_out", 32'(outData), 32'h21);
      checkOutput("t3_hold_valid", 32'(outValid), 32'h1);
      checkOutput("t3_hold_last", 32'(outLast), 32'h0);
      checkOutput("t3_hold_ready", 32'(inReady), 32'h0);
    end
    outReady = 1'b1;
    step();
    checkOutput("t3_rel_out", 32'(outData), 32'h22);
    checkOutput("t3_rel_valid", 32'(outValid), 32'h1);
    applyStimulus(0, 8'h23, 1'b1, 1'b1);
    step();
    checkOutput("t3_out_last", 32'(outData), 32'h23);
    checkOutput("t3_last", 32'(outLast), 32'h1);
    applyStimulus(0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("t3_drained", 32'(outValid), 32'h0);
    checkOutput("t3_hold_after", 32'(outData), 32'h23);

    // Out-of-range select on the three-channel instance.
    doReset();
    sel3 = 2'd3;
    step();
    checkOutput("t4_selerr", 32'(selErr3), 32'h1);
    checkOutput("t4_busy", 32'(busy3), 32'h0);
    checkOutput("t4_ready", 32'(inReady3), 32'h0);
    sel3 = 2'd0;
    step();
    checkOutput("t4_selerr_end", 32'(selErr3), 32'h0);

    // Reset during the second beat of a four-beat packet, then send a new packet.
    doReset();
    sel = 2'd2;
    applyStimulus(2, 8'hB1, 1'b1, 1'b0);
    step();
    step();
    checkOutput("t5_beat1", 32'(outData), 32'hB1);
    applyStimulus(2, 8'hB2, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    checkOutput("t5_rst_valid", 32'(outValid), 32'h0);
    checkOutput("t5_rst_out", 32'(outData), 32'h00);
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
`ifdef MUX_OUT_BAR_EN
    checkOutput("t5_rst_bar", 32'(outBar), 32'hFF);
`endif
    reset = 1'b0;
    sel   = 2'd0;
    applyStimulus(0, 8'h55, 1'b1, 1'b1);
    applyStimulus(2, 8'hB3, 1'b1, 1'b0);
    step();
    checkOutput("t5_lock_novalid", 32'(outValid), 32'h0);
    step();
    checkOutput("t5_new_out", 32'(outData), 32'h55);
    checkOutput("t5_new_last", 32'(outLast), 32'h1);
    checkOutput("t5_new_valid", 32'(outValid), 32'h1);

    // Back-to-back packets: the second packet follows after one IDLE cycle.
    doReset();
    sel = 2'd1;
    applyStimulus(1, 8'h61, 1'b1, 1'b0);
    step();
    step();
    checkOutput("t6_a0", 32'(outData), 32'h61);
    applyStimulus(1, 8'h62, 1'b1, 1'b1);
    step();
    checkOutput("t6_a1", 32'(outData), 32'h62);
    checkOutput("t6_a1_valid", 32'(outValid), 32'h1);
    applyStimulus(1, 8'h00, 1'b0, 1'b0);
    sel = 2'd3;
    applyStimulus(3, 8'h71, 1'b1, 1'b0);
    step();
    checkOutput("t6_gap", 32'(outValid), 32'h0);
    step();
    checkOutput("t6_b0", 32'(outData), 32'h71);
    checkOutput("t6_b0_valid", 32'(outValid), 32'h1);
    applyStimulus(3, 8'h72, 1'b1, 1'b1);
    step();
    checkOutput("t6_b1", 32'(outData), 32'h72);
    checkOutput("t6_b1_valid", 32'(outValid), 32'h1);
    checkOutput("t6_b1_last", 32'(outLast), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
